// File: rtl/snes_mem_pkg.sv
// Shared SDRAM-side types: ROM write word and the writer FSM encoding.
package snes_mem_pkg;

  localparam int ROM_AW = 24;

  typedef struct packed {
    logic [ROM_AW-2:0] addr;
    logic [15:0]       data;
  } rom_wr_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_WAIT = 1'b1
  } wr_state_e;

endpackage

// File: rtl/sync_fifo_1clk.sv
// Single-clock FIFO with first-word-fall-through read (rdata is the head entry).
// Handshake: a push is accepted when not full or when a pop happens in the
// same cycle; a pop is accepted when not empty.
module sync_fifo_1clk #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Next pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointer and count state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/rom_download_writer.sv
// Loader byte stream -> 16-bit little-endian words -> FIFO -> toggle req/ack
// SDRAM writes. A write is outstanding while rom_req != rom_req_ack; rom_addr
// and rom_din stay stable from the req toggle until the matching ack.
module rom_download_writer
  import snes_mem_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = ROM_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic [AW-2:0] rom_addr,
  output logic [15:0]   rom_din,
  output logic          rom_we,
  output logic          rom_req,
  input  logic          rom_req_ack,
  output logic [AW-2:0] words_written,
  output logic          done,
  output wr_state_e     dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          wr_en, dl_rise, dl_fall, ack_match;
  logic [AW-2:0] waddr;
  rom_wr_t       stale, g0, g1, first, second, head;
  logic          g0_v, g1_v, first_v, second_v;
  rom_wr_t       pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic [7:0]    pair_lo_q, pair_lo_d;
  logic [AW-2:0] pair_addr_q, pair_addr_d;
  logic          pair_valid_q, pair_valid_d;
  logic          dl_q, active_q, active_d;
  logic          wait_q, wait_d, done_q, done_d;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   count_next;
  wr_state_e     state_q;
  logic          rom_req_q, rom_we_q;
  logic [AW-2:0] rom_addr_q, words_written_q;
  logic [15:0]   rom_din_q;

  // Byte pairing: produces up to two words per cycle (g0 then g1, in order).
  always_comb begin
    wr_en        = ioctl_download & ioctl_wr;
    dl_rise      = ioctl_download & ~dl_q;
    dl_fall      = ~ioctl_download & dl_q;
    waddr        = ioctl_addr[AW-1:1];
    stale        = '{addr: pair_addr_q, data: {8'h00, pair_lo_q}};
    g0           = stale;
    g1           = stale;
    g0_v         = 1'b0;
    g1_v         = 1'b0;
    pair_lo_d    = pair_lo_q;
    pair_addr_d  = pair_addr_q;
    pair_valid_d = pair_valid_q;
    if (wr_en && !ioctl_addr[0]) begin
      g0_v         = pair_valid_q;
      pair_lo_d    = ioctl_dout;
      pair_addr_d  = waddr;
      pair_valid_d = 1'b1;
    end else if (wr_en) begin
      pair_valid_d = 1'b0;
      g0_v         = 1'b1;
      if (pair_valid_q && (pair_addr_q == waddr)) begin
        g0 = '{addr: waddr, data: {ioctl_dout, pair_lo_q}};
      end else if (pair_valid_q) begin
        g1_v = 1'b1;
        g1   = '{addr: waddr, data: {ioctl_dout, 8'h00}};
      end else begin
        g0 = '{addr: waddr, data: {ioctl_dout, 8'h00}};
      end
    end else if (dl_fall && pair_valid_q) begin
      g0_v         = 1'b1;
      pair_valid_d = 1'b0;
    end
  end

  // Push arbitration: the one-word pending slot absorbs the second word of a
  // split pair (or a word that found the FIFO full) and drains first.
  always_comb begin
    if (pend_v_q) begin
      first_v  = 1'b1;
      first    = pend_q;
      second_v = g0_v;
      second   = g0;
    end else begin
      first_v  = g0_v;
      first    = g0;
      second_v = g1_v;
      second   = g1;
    end
    ack_match = (rom_req_q == rom_req_ack);
    fifo_pop  = !fifo_empty && ((state_q == W_IDLE) || ack_match);
    fifo_push = first_v && (!fifo_full || fifo_pop);
    if (fifo_push) begin
      pend_v_d = second_v;
      pend_d   = second;
    end else begin
      pend_v_d = first_v;
      pend_d   = first;
    end
    count_next = {1'b0, fifo_count} + (CW+1)'(fifo_push) - (CW+1)'(fifo_pop);
    // A pending word also throttles the loader so the slot never overflows.
    wait_d   = (count_next >= (CW+1)'(FIFO_DEPTH - 1)) || pend_v_d;
    done_d   = active_q && !ioctl_download && fifo_empty && !pair_valid_q &&
               !pend_v_q && (state_q == W_IDLE);
    active_d = ioctl_download ? 1'b1 : (done_d ? 1'b0 : active_q);
  end

  // Pairing, pending slot, throttle and completion state.
  always_ff @(posedge clk) begin
    if (reset) begin
      pair_lo_q    <= '0;
      pair_addr_q  <= '0;
      pair_valid_q <= 1'b0;
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      dl_q         <= 1'b0;
      active_q     <= 1'b0;
      wait_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      pair_lo_q    <= pair_lo_d;
      pair_addr_q  <= pair_addr_d;
      pair_valid_q <= pair_valid_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      dl_q         <= ioctl_download;
      active_q     <= active_d;
      wait_q       <= wait_d;
      done_q       <= done_d;
    end
  end

  sync_fifo_1clk #(
    .WIDTH ($bits(rom_wr_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (first),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Write FSM: pop and req toggle share a cycle; back-to-back issue on ack.
  // During reset rom_req follows rom_req_ack so a late in-flight ack is absorbed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= W_IDLE;
      rom_req_q       <= rom_req_ack;
      rom_we_q        <= 1'b0;
      rom_addr_q      <= '0;
      rom_din_q       <= '0;
      words_written_q <= '0;
    end else begin
      if (dl_rise) begin
        words_written_q <= '0;
      end else if ((state_q == W_WAIT) && ack_match) begin
        words_written_q <= words_written_q + 1'b1;
      end
      case (state_q)
        W_IDLE: begin
          if (fifo_pop) begin
            rom_addr_q <= head.addr;
            rom_din_q  <= head.data;
            rom_we_q   <= 1'b1;
            rom_req_q  <= ~rom_req_q;
            state_q    <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (ack_match) begin
            if (fifo_pop) begin
              rom_addr_q <= head.addr;
              rom_din_q  <= head.data;
              rom_req_q  <= ~rom_req_q;
            end else begin
              rom_we_q <= 1'b0;
              state_q  <= W_IDLE;
            end
          end
        end
        default: state_q <= W_IDLE;
      endcase
    end
  end

  assign ioctl_wait    = wait_q;
  assign rom_addr      = rom_addr_q;
  assign rom_din       = rom_din_q;
  assign rom_we        = rom_we_q;
  assign rom_req       = rom_req_q;
  assign words_written = words_written_q;
  assign done          = done_q;
  assign dbg_state     = state_q;

endmodule
